instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Inverse of the control decoder: encodes MIPS-subset instructions (R-type, addiu, andi, beq, bne,
//  lw, sw, j) from separate fields into 32-bit words and streams them into instruction memory.
//  Encoded words are buffered in a FIFO and written to sequential addresses from BASE_ADDR.
//  Sits between the bench/boot loader and the instruction-memory write port.
// PARAMETERS
//  DEPTH      4   FIFO entries of encoded words (power of 2, >=2)
//  ADDR_W     8   instruction-memory word-address width
//  BASE_ADDR  0   first write address after start
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   pulse; begins a load session (honoured only in IDLE)
//  in_valid    in   1   field bundle valid
//  in_ready    out  1   encoder can accept bundle
//  in_last     in   1   marks final instruction of session
//  op_sel      in   3   0=R 1=addiu 2=andi 3=beq 4=bne 5=lw 6=sw 7=j
//  rs,rt,rd    in   5   register fields
//  shamt       in   5   shift amount (R only)
//  funct       in   6   function code (R only)
//  imm         in   16  immediate / branch offset (I-types)
//  target      in   26  jump target (j only)
//  imem_we     out  1   write request to instruction memory
//  imem_ready  in   1   memory accepts write this cycle
//  imem_addr   out  ADDR_W  write address
//  imem_wdata  out  32  encoded instruction word
//  word_cnt    out  ADDR_W+1  words written this session
//  done        out  1   one-cycle pulse, session complete
//  wrap_err    out  1   sticky: address wrapped past 2^ADDR_W-1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, FIFO empty, imem_addr=BASE_ADDR; all other outputs 0.
//  Opcodes: R 000000, addiu 001001, andi 001100, beq 000100, bne 000101, lw 100011, sw 101011, j 000010.
//  R: {op,rs,rt,rd,shamt,funct}; I-types: {op,rs,rt,imm}; j: {op,target}; unused fields ignored.
//  Encoding is combinational on accept; encoded word pushed into FIFO in the accept cycle.
//  Accept = in_valid & in_ready; in_ready = (state==LOAD) & !fifo_full.
//  imem_we = !fifo_empty & (state==LOAD|DRAIN); imem_wdata = FIFO head; held stable while imem_ready=0.
//  Write completes on imem_we & imem_ready: pop, imem_addr++, word_cnt++.
//  Latency: accepted bundle reaches imem_wdata no earlier than next cycle; 1 write/cycle max.
//  Push and pop in same cycle: occupancy unchanged. No push when full (in_ready low).
//  imem_addr at 2^ADDR_W-1 + write -> wraps to 0, wrap_err=1 until next start.
//  FSM:
//   IDLE : start -> LOAD; imem_addr=BASE_ADDR, word_cnt=0, wrap_err=0.
//   LOAD : accept with in_last=1 -> DRAIN. start ignored.
//   DRAIN: no accepts; FIFO empty (final pop done) -> DONE.
//   DONE : done=1 for exactly this cycle -> IDLE. word_cnt/imem_addr/wrap_err hold until next start.
//  Reset mid-session: FIFO contents discarded, back to IDLE; no partial write issued afterwards.
// TESTING
//  T1 encode: R rs=1 rt=2 rd=3 funct=0x20 ->0x00221820; addiu rs=2 rt=3 imm=0x10 ->0x24430010;
//     lw rs=29 rt=8 imm=4 ->0x8FA80004; sw rs=29 rt=31 imm=0xFFFC ->0xAFBFFFFC; j target=0x0100000 ->0x08100000.
//  T2 backpressure: imem_ready=0, offer 6 bundles (DEPTH=4) -> in_ready low after 4 accepts;
//     raise imem_ready -> writes at addr 0,1,2,3,4,5 in order, data unchanged during stall.
//  T3 session end: 3 bundles, in_last on 3rd -> DRAIN, done high 1 cycle after 3rd write, word_cnt=3.
//  T4 wrap: ADDR_W=4, BASE_ADDR=14, 3 words -> addrs 14,15,0; wrap_err=1; next start clears it.
//  T5 reset in DRAIN with 2 words queued -> imem_we=0, in_ready=0, done=0; fresh start loads from BASE_ADDR.
//  T6 start pulsed during LOAD -> ignored; imem_addr and word_cnt continue uninterrupted.

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// -----------------------------------------------------------------------------
// instruction_encoder_loader
//
// Encodes MIPS-subset instructions (R-type, addiu, andi, beq, bne, lw, sw, j)
// from separate fields into 32-bit words. The words are queued in a small FIFO
// and written to instruction memory at sequential word addresses starting at
// BASE_ADDR. A session is opened by `start`, closed by the bundle marked
// `in_last`, and ends with a one-cycle `done` pulse once the FIFO has drained.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             pulse, opens a session (only honoured when idle)
//   in_valid/in_ready field-bundle handshake; in_last marks the final bundle
//   op_sel            0=R 1=addiu 2=andi 3=beq 4=bne 5=lw 6=sw 7=j
//   rs, rt, rd, shamt, funct, imm, target   instruction fields
//   imem_we/imem_ready  memory write handshake
//   imem_addr, imem_wdata  write address / encoded word (FIFO head)
//   word_cnt          words written this session
//   done              one-cycle pulse at session end
//   wrap_err          sticky, address wrapped past 2^ADDR_W-1 this session
// -----------------------------------------------------------------------------
module instruction_encoder_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              done,
  output logic              wrap_err
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       fifo_mem [DEPTH];
  logic [31:0]       enc_word;
  logic              fifo_empty, fifo_full, push, pop;

  // ---------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    enc_word = '0;
    case (op_sel)
      3'd0:    enc_word = {OP_R, rs, rt, rd, shamt, funct};
      3'd1:    enc_word = {OP_ADDIU, rs, rt, imm};
      3'd2:    enc_word = {OP_ANDI, rs, rt, imm};
      3'd3:    enc_word = {OP_BEQ, rs, rt, imm};
      3'd4:    enc_word = {OP_BNE, rs, rt, imm};
      3'd5:    enc_word = {OP_LW, rs, rt, imm};
      3'd6:    enc_word = {OP_SW, rs, rt, imm};
      default: enc_word = {OP_J, target};
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra bit to tell full from empty
  // ---------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign in_ready   = (state_q == S_LOAD) && !fifo_full;
  assign imem_we    = !fifo_empty && ((state_q == S_LOAD) || (state_q == S_DRAIN));
  assign push       = in_valid && in_ready;
  assign pop        = imem_we && imem_ready;

  assign wr_ptr_d   = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= enc_word;
  end

  // Drive zero when nothing is offered so stale entries never appear on the bus.
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr_q[PTR_W-1:0]] : '0;

  // ---------------------------------------------------------------------------
  // Session control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    if (pop) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q + (ADDR_W+1)'(1);
      if (addr_q == '1) wrap_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = BASE;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      S_LOAD:  if (push && in_last) state_d = S_DRAIN;
      // Leave as soon as the final pop empties the FIFO, so done follows the last write directly.
      S_DRAIN: if (wr_ptr_d == rd_ptr_d) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= BASE;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign imem_addr = addr_q;
  assign word_cnt  = cnt_q;
  assign done      = (state_q == S_DONE);
  assign wrap_err  = wrap_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder_loader
//
// Two instances share all inputs: A uses the default geometry (ADDR_W=8,
// BASE_ADDR=0), B uses ADDR_W=4, BASE_ADDR=14 so every session of three or
// more words wraps. A session-level reference model (queue of encoded words,
// count of words written, session phase) predicts every output of both
// instances on each falling edge.
// -----------------------------------------------------------------------------
module tb_instruction_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        imem_ready = 1'b0;
  int          rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random each cycle

  logic        in_ready_a, imem_we_a, done_a, wrap_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;

  logic        in_ready_b, imem_we_b, done_b, wrap_b;
  logic [3:0]  addr_b;
  logic [31:0] wdata_b;
  logic [4:0]  cnt_b;

  instruction_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .imem_we(imem_we_a), .imem_ready(imem_ready),
    .imem_addr(addr_a), .imem_wdata(wdata_a), .word_cnt(cnt_a), .done(done_a), .wrap_err(wrap_a)
  );

  instruction_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .imem_we(imem_we_b), .imem_ready(imem_ready),
    .imem_addr(addr_b), .imem_wdata(wdata_b), .word_cnt(cnt_b), .done(done_b), .wrap_err(wrap_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    imem_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {PH_IDLE, PH_LOAD, PH_DRAIN, PH_DONE} phase_t;

  phase_t      ph = PH_IDLE;
  logic [31:0] q[$];
  logic [31:0] gold_q[$];
  int          n_written = 0;
  int          acc_seen = 0;
  logic        exp_rdy, exp_we, will_acc, will_wr;

  function automatic logic [31:0] model_encode(input int op, input int f_rs, input int f_rt,
                                               input int f_rd, input int f_sh, input int f_fn,
                                               input int f_imm, input int f_tgt);
    int unsigned opc [8] = '{0, 9, 12, 4, 5, 35, 43, 2};
    int unsigned w;
    if (op == 0)
      w = (f_rs << 21) + (f_rt << 16) + (f_rd << 11) + (f_sh << 6) + f_fn;
    else if (op == 7)
      w = (opc[7] << 26) + f_tgt;
    else
      w = (opc[op] << 26) + (f_rs << 21) + (f_rt << 16) + f_imm;
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      gold_q.delete();
      ph = PH_IDLE;
      n_written = 0;
    end
    exp_rdy = (ph == PH_LOAD) && (q.size() < DEPTH);
    exp_we  = ((ph == PH_LOAD) || (ph == PH_DRAIN)) && (q.size() > 0);
    check("in_ready_a", in_ready_a, exp_rdy);
    check("in_ready_b", in_ready_b, exp_rdy);
    check("imem_we_a", imem_we_a, exp_we);
    check("imem_we_b", imem_we_b, exp_we);
    check("done_a", done_a, ph == PH_DONE);
    check("done_b", done_b, ph == PH_DONE);
    check("word_cnt_a", cnt_a, n_written);
    check("word_cnt_b", cnt_b, n_written);
    check("addr_a", addr_a, n_written % 256);
    check("addr_b", addr_b, (14 + n_written) % 16);
    check("wrap_a", wrap_a, n_written >= 256);
    check("wrap_b", wrap_b, (14 + n_written) >= 16);
    if (exp_we) begin
      check("wdata_a", wdata_a, q[0]);
      check("wdata_b", wdata_b, q[0]);
    end
    if (rst_n) begin
      if (in_valid && in_ready_a) acc_seen++;
      will_acc = in_valid && exp_rdy;
      will_wr  = exp_we && imem_ready;
      if (will_wr) begin
        if (gold_q.size() > 0) check("t1_golden", wdata_a, gold_q.pop_front());
        void'(q.pop_front());
        n_written++;
      end
      if (will_acc)
        q.push_back(model_encode(op_sel, rs, rt, rd, shamt, funct, imm, target));
      case (ph)
        PH_IDLE:  if (start) begin ph = PH_LOAD; n_written = 0; end
        PH_LOAD:  if (will_acc && in_last) ph = PH_DRAIN;
        PH_DRAIN: if (q.size() == 0) ph = PH_DONE;
        default:  ph = PH_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all return just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                      input logic [15:0] a_imm, input logic [25:0] a_tgt, input logic last);
    logic rdy;
    in_valid = 1'b1;
    op_sel = op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh; funct = a_fn;
    imm = a_imm; target = a_tgt; in_last = last;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rdy = in_ready_a;
      tick();
      if (rdy) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_rand(input logic last);
    send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         6'($urandom), 16'($urandom), 26'($urandom), last);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_a) begin
        tick();
        return;
      end
      tick();
    end
    check("done_timeout", 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 1'b0);
    check("rst_we", imem_we_a, 1'b0);
    check("rst_wdata", wdata_a, 32'h0);
    check("rst_done", done_a, 1'b0);
    check("rst_addr_b", addr_b, 4'd14);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: known encodings
    rdy_mode = 1;
    do_start();
    gold_q.push_back(32'h00221820); send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    gold_q.push_back(32'h24430010); send(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b0);
    gold_q.push_back(32'h8FA80004); send(3'd5, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    gold_q.push_back(32'hAFBFFFFC); send(3'd6, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0);
    gold_q.push_back(32'h08100000); send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b1);
    wait_done();
    check("t1_word_cnt", cnt_a, 9'd5);
    check("t1_gold_drained", gold_q.size(), 0);

    // T2: backpressure with six bundles against a four-deep FIFO
    rdy_mode = 0;
    tick();
    do_start();
    acc_seen = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(i == 5);
      end
      begin
        repeat (12) tick();
        @(negedge clk);
        check("t2_ready_low", in_ready_a, 1'b0);
        check("t2_accepts_stalled", acc_seen, 4);
        check("t2_no_writes", cnt_a, 9'd0);
        tick();
        rdy_mode = 1;
      end
    join
    wait_done();
    check("t2_word_cnt", cnt_a, 9'd6);
    check("t2_last_addr", addr_a, 8'd6);

    // T3 / T4: three-word session; instance B writes 14,15,0 and flags the wrap
    do_start();
    for (int i = 0; i < 3; i++) send_rand(i == 2);
    wait_done();
    check("t3_word_cnt", cnt_a, 9'd3);
    check("t4_wrap_b", wrap_b, 1'b1);
    check("t4_addr_b", addr_b, 4'd1);
    check("t4_no_wrap_a", wrap_a, 1'b0);

    // T5: reset while draining two queued words
    rdy_mode = 0;
    tick();
    do_start();
    send_rand(1'b0);
    send_rand(1'b1);
    repeat (2) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_we", imem_we_a, 1'b0);
    check("t5_in_ready", in_ready_a, 1'b0);
    check("t5_done", done_a, 1'b0);
    tick();
    rdy_mode = 1;
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("t5_no_partial_write", imem_we_a, 1'b0);
    do_start();
    for (int i = 0; i < 2; i++) send_rand(i == 1);
    wait_done();
    check("t5_fresh_cnt", cnt_a, 9'd2);

    // T6: start pulsed mid-session is ignored
    do_start();
    send_rand(1'b0);
    send_rand(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done();
    check("t6_word_cnt", cnt_a, 9'd4);
    check("t6_addr", addr_a, 8'd4);

    // Randomized sessions with random memory backpressure and input gaps
    rdy_mode = 2;
    for (int s = 0; s < 8; s++) begin
      int len;
      len = $urandom_range(1, 9);
      do_start();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_rand(i == len - 1);
      end
      wait_done();
      check("rand_word_cnt", cnt_a, len);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
